// File: rtl/piece_move_ctrl.sv
// Falling-piece move sequencer: issues candidate moves to a registered collision
// checker, then commits, rejects, or hands the piece to the board for locking.
module piece_move_ctrl #(
   parameter logic [3:0] SPAWN_X = 4'd6,
   parameter logic [4:0] SPAWN_Y = 5'd19
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd_op,
   input  logic [15:0] spawn_float,
   output logic        cmd_ready,
   output logic [3:0]  chk_pos_x,
   output logic [4:0]  chk_pos_y,
   output logic [15:0] chk_float,
   input  logic        chk_valid,
   output logic [3:0]  piece_x,
   output logic [4:0]  piece_y,
   output logic [15:0] piece_float,
   output logic        piece_active,
   output logic        done,
   output logic        accepted,
   output logic        lock_req,
   input  logic        lock_ack,
   output logic        game_over
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EVAL = 2'd2,
      ST_LOCK = 2'd3
   } state_t;

   localparam logic [2:0] OP_SPAWN  = 3'd0;
   localparam logic [2:0] OP_LEFT   = 3'd1;
   localparam logic [2:0] OP_RIGHT  = 3'd2;
   localparam logic [2:0] OP_ROTATE = 3'd3;
   localparam logic [2:0] OP_DOWN   = 3'd4;
   localparam logic [2:0] OP_HARD   = 3'd5;

   // Clockwise quarter turn inside the 4x4 box: cell (row, col) moves to (3-col, row).
   function automatic logic [15:0] rotate_cw(input logic [15:0] old);
      logic [15:0] rot;
      rot = 16'h0000;
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            rot[4'((3 - col) * 4 + row)] = old[4'(row * 4 + col)];
         end
      end
      return rot;
   endfunction

   state_t      state_r, state_s;
   logic [2:0]  op_r, op_s;
   logic [3:0]  chk_x_s, piece_x_s;
   logic [4:0]  chk_y_s, piece_y_s;
   logic [15:0] chk_float_s, piece_float_s;
   logic        active_s, done_s, acc_s, lock_s, over_s, ready_s;
   logic        reject_s;

   // A SPAWN is legal only with no piece in play; every other op needs one.
   assign reject_s = game_over
                   | (cmd_op > OP_HARD)
                   | ((cmd_op == OP_SPAWN) && piece_active)
                   | ((cmd_op != OP_SPAWN) && !piece_active);

   // Next-state, candidate and commit logic.
   always_comb begin
      state_s       = state_r;
      op_s          = op_r;
      chk_x_s       = chk_pos_x;
      chk_y_s       = chk_pos_y;
      chk_float_s   = chk_float;
      piece_x_s     = piece_x;
      piece_y_s     = piece_y;
      piece_float_s = piece_float;
      active_s      = piece_active;
      done_s        = 1'b0;
      acc_s         = 1'b0;
      lock_s        = lock_req;
      over_s        = game_over;

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_s = cmd_op;
               if (reject_s) begin
                  done_s = 1'b1;
               end else begin
                  state_s     = ST_WAIT;
                  chk_x_s     = piece_x;
                  chk_y_s     = piece_y;
                  chk_float_s = piece_float;
                  case (cmd_op)
                     OP_SPAWN: begin
                        chk_x_s     = SPAWN_X;
                        chk_y_s     = SPAWN_Y;
                        chk_float_s = spawn_float;
                     end
                     OP_LEFT:   chk_x_s     = piece_x - 4'd1;
                     OP_RIGHT:  chk_x_s     = piece_x + 4'd1;
                     OP_ROTATE: chk_float_s = rotate_cw(piece_float);
                     OP_DOWN:   chk_y_s     = piece_y - 5'd1;
                     OP_HARD:   chk_y_s     = piece_y - 5'd1;
                     default:   state_s     = ST_IDLE;
                  endcase
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_WAIT: begin
            state_s = ST_EVAL;
         end

         ST_EVAL: begin
            if (chk_valid) begin
               piece_x_s     = chk_pos_x;
               piece_y_s     = chk_pos_y;
               piece_float_s = chk_float;
               if (op_r == OP_SPAWN) begin
                  active_s = 1'b1;
               end else begin
                  active_s = piece_active;
               end
               if (op_r == OP_HARD) begin
                  chk_y_s = chk_pos_y - 5'd1;
                  state_s = ST_WAIT;
               end else begin
                  state_s = ST_IDLE;
                  done_s  = 1'b1;
                  acc_s   = 1'b1;
               end
            end else begin
               case (op_r)
                  OP_SPAWN: begin
                     over_s  = 1'b1;
                     state_s = ST_IDLE;
                     done_s  = 1'b1;
                  end
                  OP_DOWN, OP_HARD: begin
                     state_s = ST_LOCK;
                     lock_s  = 1'b1;
                  end
                  default: begin
                     state_s = ST_IDLE;
                     done_s  = 1'b1;
                  end
               endcase
            end
         end

         ST_LOCK: begin
            if (lock_ack) begin
               lock_s   = 1'b0;
               active_s = 1'b0;
               done_s   = 1'b1;
               acc_s    = (op_r == OP_HARD);
               state_s  = ST_IDLE;
            end else begin
               state_s = ST_LOCK;
            end
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      ready_s = (state_s == ST_IDLE);
   end

   // State and output registers; reset abandons any command or lock in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         op_r         <= OP_SPAWN;
         cmd_ready    <= 1'b1;
         chk_pos_x    <= 4'd0;
         chk_pos_y    <= 5'd0;
         chk_float    <= 16'h0000;
         piece_x      <= SPAWN_X;
         piece_y      <= SPAWN_Y;
         piece_float  <= 16'h0000;
         piece_active <= 1'b0;
         done         <= 1'b0;
         accepted     <= 1'b0;
         lock_req     <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state_r      <= state_s;
         op_r         <= op_s;
         cmd_ready    <= ready_s;
         chk_pos_x    <= chk_x_s;
         chk_pos_y    <= chk_y_s;
         chk_float    <= chk_float_s;
         piece_x      <= piece_x_s;
         piece_y      <= piece_y_s;
         piece_float  <= piece_float_s;
         piece_active <= active_s;
         done         <= done_s;
         accepted     <= acc_s;
         lock_req     <= lock_s;
         game_over    <= over_s;
      end
   end

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed self-checking bench for piece_move_ctrl; the collision checker is
// replaced by chk_valid values chosen per step.
module tb_piece_move_ctrl;

   localparam logic [2:0] OP_SPAWN  = 3'd0;
   localparam logic [2:0] OP_LEFT   = 3'd1;
   localparam logic [2:0] OP_RIGHT  = 3'd2;
   localparam logic [2:0] OP_ROTATE = 3'd3;
   localparam logic [2:0] OP_DOWN   = 3'd4;
   localparam logic [2:0] OP_HARD   = 3'd5;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, chk_valid, lock_ack;
   logic [2:0]  cmd_op;
   logic [15:0] spawn_float;
   logic        cmd_ready, piece_active, done, accepted, lock_req, game_over;
   logic [3:0]  chk_pos_x, piece_x;
   logic [4:0]  chk_pos_y, piece_y;
   logic [15:0] chk_float, piece_float;

   int tests  = 0;
   int failed = 0;
   int seen_done;

   piece_move_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .spawn_float(spawn_float), .cmd_ready(cmd_ready),
      .chk_pos_x(chk_pos_x), .chk_pos_y(chk_pos_y), .chk_float(chk_float),
      .chk_valid(chk_valid), .piece_x(piece_x), .piece_y(piece_y),
      .piece_float(piece_float), .piece_active(piece_active), .done(done),
      .accepted(accepted), .lock_req(lock_req), .lock_ack(lock_ack),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [15:0] flt);
      cmd_op      = op;
      spawn_float = flt;
      cmd_valid   = 1'b1;
      tick();
      cmd_valid   = 1'b0;
   endtask

   // Accept, WAIT, EVAL: returns in the cycle where done is visible.
   task automatic run(input logic [2:0] op, input logic [15:0] flt, input logic v);
      chk_valid = v;
      issue(op, flt);
      tick();
      tick();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"},  {31'd0, cmd_ready},    32'd1);
      check({tag, "_chk"},    {7'd0, chk_pos_x, chk_pos_y, chk_float}, 32'd0);
      check({tag, "_piece"},  {7'd0, piece_x, piece_y, piece_float}, {7'd0, 4'd6, 5'd19, 16'h0000});
      check({tag, "_flags"},  {27'd0, piece_active, done, accepted, lock_req, game_over}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; spawn_float = 16'h0000;
      chk_valid = 1'b0; lock_ack = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_reset("rst0");

      // 1: SPAWN 0066 on an empty board
      chk_valid = 1'b1;
      issue(OP_SPAWN, 16'h0066);
      check("sp_chk", {7'd0, chk_pos_x, chk_pos_y, chk_float}, {7'd0, 4'd6, 5'd19, 16'h0066});
      check("sp_busy", {31'd0, cmd_ready}, 32'd0);
      tick();
      check("sp_done_early", {31'd0, done}, 32'd0);
      tick();
      check("sp_done", {30'd0, done, accepted}, 32'd3);
      check("sp_piece", {7'd0, piece_x, piece_y, piece_float}, {7'd0, 4'd6, 5'd19, 16'h0066});
      check("sp_active", {31'd0, piece_active}, 32'd1);
      tick();
      check("sp_done_pulse", {31'd0, done}, 32'd0);

      // 2: walk to x=0, then LEFT wraps to 15 and the checker refuses it
      for (int i = 0; i < 6; i++) run(OP_LEFT, 16'h0000, 1'b1);
      check("walk_x", {28'd0, piece_x}, 32'd0);
      chk_valid = 1'b0;
      issue(OP_LEFT, 16'h0000);
      check("wrap_chk_x", {28'd0, chk_pos_x}, 32'hF);
      tick(); tick();
      check("wrap_done", {30'd0, done, accepted}, 32'd2);
      check("wrap_px", {28'd0, piece_x}, 32'd0);
      issue(3'd7, 16'h0000);
      check("resv_done", {30'd0, done, accepted}, 32'd2);
      check("resv_chk", {28'd0, chk_pos_x}, 32'hF);
      check("resv_ready", {31'd0, cmd_ready}, 32'd1);

      // 3: row-1 bar rotates into column 1, then into row 2
      rst = 1'b1; tick(); rst = 1'b0;
      run(OP_SPAWN, 16'h00F0, 1'b1);
      chk_valid = 1'b1;
      issue(OP_ROTATE, 16'h0000);
      check("rot_chk", {7'd0, chk_pos_x, chk_pos_y, chk_float}, {7'd0, 4'd6, 5'd19, 16'h2222});
      tick(); tick();
      check("rot_done", {30'd0, done, accepted}, 32'd3);
      check("rot_piece", {7'd0, piece_x, piece_y, piece_float}, {7'd0, 4'd6, 5'd19, 16'h2222});
      run(OP_ROTATE, 16'h0000, 1'b1);
      check("rot2_piece", {16'd0, piece_float}, 32'h0F00);
      run(OP_RIGHT, 16'h0000, 1'b1);
      check("right_x", {28'd0, piece_x}, 32'd7);

      // 4: HARD_DROP from y=19, 16 free steps, then lock
      chk_valid = 1'b1;
      issue(OP_HARD, 16'h0000);
      check("hd_chk_y", {27'd0, chk_pos_y}, 32'd18);
      seen_done = 0;
      for (int k = 0; k < 17; k++) begin
         chk_valid = (k < 16);
         tick();
         tick();
         if (done) seen_done++;
      end
      check("hd_no_done", seen_done, 32'd0);
      check("hd_piece_y", {27'd0, piece_y}, 32'd3);
      check("hd_chk_y_last", {27'd0, chk_pos_y}, 32'd2);
      check("hd_lock", {31'd0, lock_req}, 32'd1);
      tick(); tick();
      check("hd_lock_held", {30'd0, lock_req, done}, 32'd2);
      lock_ack = 1'b1;
      tick();
      lock_ack = 1'b0;
      check("hd_done", {30'd0, done, accepted}, 32'd3);
      check("hd_released", {30'd0, lock_req, piece_active}, 32'd0);

      // 5: colliding SPAWN ends the game; later SPAWN is refused at once
      run(OP_SPAWN, 16'h0660, 1'b0);
      check("go_done", {30'd0, done, accepted}, 32'd2);
      check("go_flags", {30'd0, game_over, piece_active}, 32'd2);
      check("go_piece_y", {27'd0, piece_y}, 32'd3);
      chk_valid = 1'b1;
      issue(OP_SPAWN, 16'h1234);
      check("go_rej_done", {30'd0, done, accepted}, 32'd2);
      check("go_rej_chk", {16'd0, chk_float}, 32'h0660);
      check("go_rej_ready", {31'd0, cmd_ready}, 32'd1);

      // 6: reset during WAIT of RIGHT, DOWN lock with same-cycle ack, reset during LOCK
      rst = 1'b1; tick(); rst = 1'b0;
      run(OP_SPAWN, 16'h0066, 1'b1);
      issue(OP_RIGHT, 16'h0000);
      rst = 1'b1; tick(); rst = 1'b0;
      check_reset("rst_wait");
      tick(); tick();
      check("rst_wait_nodone", {31'd0, done}, 32'd0);
      run(OP_SPAWN, 16'h0066, 1'b1);
      run(OP_DOWN, 16'h0000, 1'b0);
      check("dn_lock", {30'd0, lock_req, done}, 32'd2);
      lock_ack = 1'b1;
      tick();
      lock_ack = 1'b0;
      check("dn_done", {30'd0, done, accepted}, 32'd2);
      check("dn_active", {31'd0, piece_active}, 32'd0);
      run(OP_SPAWN, 16'h0066, 1'b1);
      run(OP_DOWN, 16'h0000, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      check_reset("rst_lock");
      tick();
      check("rst_lock_nodone", {30'd0, done, lock_req}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
